// File: rtl/serial_ripple_subtractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub_pkg
//  Description : Shared types and helpers for the bit-serial ripple-borrow
//                subtractor: FSM state encoding, default operand width and
//                the bit-counter width helper.
//  Revision    : 1.0  - initial release
// ============================================================================
package serial_sub_pkg;

   // Default operand/result width.
   localparam int unsigned SUB_WIDTH_DEF = 4;

   // Operation sequencer states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_t;

   // Width of the bit counter, which has to reach WIDTH-1.
   // At least one bit wide, so the counter never collapses to a zero-width
   // vector.
   function automatic int unsigned sub_cnt_width(input int unsigned width);
      int unsigned w;
      w = $clog2(width);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/serial_ripple_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_ripple_subtractor_if
//  Description : Operand/result handshake bundle for the serial subtractor.
//                master: producer of operands and consumer of results.
//                slave : the subtractor itself.
//  Signals     : in_valid/in_ready, a, b, bin   - operand channel
//                out_valid/out_ready, diff, bout - result channel
//                ovf                             - signed overflow, present
//                                                  only with SUB_OVERFLOW_EN
//  Revision    : 1.0  - initial release
// ============================================================================
interface serial_ripple_subtractor_if #(
   parameter int unsigned WIDTH = serial_sub_pkg::SUB_WIDTH_DEF
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SUB_OVERFLOW_EN
   logic             ovf;
`endif

   modport master (
      output in_valid,
      input  in_ready,
      output a,
      output b,
      output bin,
      input  out_valid,
      output out_ready,
      input  diff,
`ifdef SUB_OVERFLOW_EN
      input  ovf,
`endif
      input  bout
   );

   modport slave (
      input  in_valid,
      output in_ready,
      input  a,
      input  b,
      input  bin,
      output out_valid,
      input  out_ready,
      output diff,
`ifdef SUB_OVERFLOW_EN
      output ovf,
`endif
      output bout
   );

endinterface : serial_ripple_subtractor_if
`default_nettype wire

// File: rtl/serial_ripple_subtractor_fs.sv
`default_nettype none
// ============================================================================
//  Module      : full_subtractor
//  Description : One-bit combinational full subtractor, a - b - bin.
//  Ports       : a, b, bin (inputs)  d (difference), bout (borrow out)
//  Revision    : 1.0  - initial release
// ============================================================================
module full_subtractor (
   input  wire logic a,
   input  wire logic b,
   input  wire logic bin,
   output logic      d,
   output logic      bout
);

   logic w_axb;

   assign w_axb = a ^ b;
   assign d     = w_axb ^ bin;
   // Borrow when b exceeds a outright, or when a equals b and a borrow is
   // already pending.
   assign bout  = (~a & b) | (~w_axb & bin);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_ripple_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_ripple_subtractor
//  Description : Bit-serial ripple-borrow subtractor. Computes
//                (a - b - bin) mod 2^WIDTH over WIDTH cycles, LSB first, with
//                a single full-subtractor cell and a registered borrow.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - serial_ripple_subtractor_if.slave
//                         (operand channel in, result channel out)
//  Parameters  : WIDTH  - operand/result width, legal range 2..32
//  Options     : `define SUB_OVERFLOW_EN adds the registered signed-overflow
//                flag bus.ovf
//  Revision    : 1.0  - initial release
// ============================================================================
module serial_ripple_subtractor
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = SUB_WIDTH_DEF
) (
   input  wire logic                 clk,
   input  wire logic                 rst_n,
   serial_ripple_subtractor_if.slave bus
);

   localparam int unsigned          c_cnt_w    = sub_cnt_width(WIDTH);
   localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(WIDTH - 1);
   localparam logic [c_cnt_w-1:0]   c_cnt_one  = c_cnt_w'(1);

   sub_state_t         r_state;
   logic [WIDTH-1:0]   r_a_sh;
   logic [WIDTH-1:0]   r_b_sh;
   logic [WIDTH-1:0]   r_diff;
   logic               r_borrow;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_in_ready;
   logic               r_out_valid;
`ifdef SUB_OVERFLOW_EN
   logic               r_ovf;
`endif

   logic               w_d;
   logic               w_bo;

   // The only arithmetic cell; it is reused for every bit position.
   full_subtractor u_fs (
      .a    (r_a_sh[0]),
      .b    (r_b_sh[0]),
      .bin  (r_borrow),
      .d    (w_d),
      .bout (w_bo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_a_sh      <= '0;
         r_b_sh      <= '0;
         r_diff      <= '0;
         r_borrow    <= 1'b0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
`ifdef SUB_OVERFLOW_EN
         r_ovf       <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  // Operands are captured once; later changes on the bus are
                  // irrelevant until the next acceptance.
                  r_a_sh     <= bus.a;
                  r_b_sh     <= bus.b;
                  r_borrow   <= bus.bin;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
`ifdef SUB_OVERFLOW_EN
                  r_ovf      <= 1'b0;
`endif
                  r_state    <= RUN;
               end
            end

            RUN: begin
               // Each new bit enters at the MSB, so after WIDTH cycles the
               // first (LSB) result bit has walked down to bit 0.
               r_diff   <= {w_d, r_diff[WIDTH-1:1]};
               r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
               r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
               r_borrow <= w_bo;
               r_cnt    <= r_cnt + c_cnt_one;
               if (r_cnt == c_cnt_last) begin
                  r_out_valid <= 1'b1;
`ifdef SUB_OVERFLOW_EN
                  // On the last bit the shift registers hold the original
                  // operand MSBs at position 0 and w_d is the result MSB.
                  r_ovf       <= (r_a_sh[0] != r_b_sh[0]) && (w_d != r_a_sh[0]);
`endif
                  r_state     <= DONE;
               end
            end

            DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end

            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.diff      = r_diff;
   // The borrow flop holds the final borrow once the last bit is processed.
   assign bus.bout      = r_borrow;
`ifdef SUB_OVERFLOW_EN
   assign bus.ovf       = r_ovf;
`endif

endmodule : serial_ripple_subtractor
`default_nettype wire

// File: tb/tb_serial_ripple_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_ripple_subtractor
//  Description : Directed self-checking bench for serial_ripple_subtractor,
//                WIDTH=4. Build with SUB_OVERFLOW_EN defined to also check
//                the overflow flag.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_serial_ripple_subtractor;

   localparam int unsigned WIDTH = 4;

   logic clk;
   logic rst_n;

   int n_vec;
   int n_err;

   serial_ripple_subtractor_if #(.WIDTH(WIDTH)) bus ();

   serial_ripple_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present operands for one edge, then measure latency to out_valid.
   task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                         input logic binv, input logic [3:0] exp_d, input logic exp_b,
                         input logic exp_ovf);
      int lat;
      bus.a        = av;
      bus.b        = bv;
      bus.bin      = binv;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      bus.a        = ~av;
      bus.b        = ~bv;
      chk({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (bus.out_valid) begin
            lat = i;
            break;
         end
      end
      chk({tag, "_latency"}, 32'(lat), 32'd4);
      chk({tag, "_diff"}, 32'(bus.diff), 32'(exp_d));
      chk({tag, "_bout"}, 32'(bus.bout), 32'(exp_b));
`ifdef SUB_OVERFLOW_EN
      chk({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
`else
      if (exp_ovf === 1'bx) begin
         $display("note: unexpected ovf argument");
      end
`endif
   endtask

   // Accept the held result and confirm the block is ready again next cycle.
   task automatic release_result(input string tag);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk({tag, "_out_valid_low"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_in_ready_high"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      n_vec         = 0;
      n_err         = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.bin       = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state
      step();
      step();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_diff", 32'(bus.diff), 32'd0);
      chk("rst_bout", 32'(bus.bout), 32'd0);
`ifdef SUB_OVERFLOW_EN
      chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
      rst_n = 1'b1;
      step();

      // Basic arithmetic
      run_op("9m3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1);
      release_result("9m3");
      run_op("3m9", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1);
      release_result("3m9");
      run_op("0m0b1", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);
      release_result("0m0b1");
      run_op("FmF", 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);

      // Backpressure: result held, new operands ignored while in DONE
      bus.a        = 4'd1;
      bus.b        = 4'd1;
      bus.bin      = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_diff", 32'(bus.diff), 32'h0);
         chk("bp_bout", 32'(bus.bout), 32'd0);
      end
      bus.in_valid = 1'b0;
      release_result("FmF");
      run_op("5m2", 4'd5, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0);
      release_result("5m2");

      // Reset two cycles into RUN
      bus.a        = 4'hF;
      bus.b        = 4'd1;
      bus.bin      = 1'b0;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_diff", 32'(bus.diff), 32'd0);
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("mid_rst_bout", 32'(bus.bout), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      run_op("8m1", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1);
      release_result("8m1");

      // Signed-overflow corner cases
      run_op("7m8", 4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1);
      release_result("7m8");
      run_op("5m3", 4'd5, 4'd3, 1'b0, 4'd2, 1'b0, 1'b0);
      release_result("5m3");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_serial_ripple_subtractor
`default_nettype wire

// File: doc/serial_ripple_subtractor.md
# serial_ripple_subtractor

Bit-serial ripple-borrow subtractor: the inverse-operation companion to the team's parallel ripple-carry adder. It computes `a - b - bin` over WIDTH cycles, one bit per cycle, LSB first, by time-multiplexing a single full-subtractor cell with a registered borrow. Operands enter and results leave through valid/ready handshakes. It sits on area-constrained datapaths where a WIDTH-cell ripple chain is not affordable.

## Interface
Parameters:
- `WIDTH`, default 4. Operand and result width; legal range is 2 to 32.

Ports:
- `clk`, input, 1. Single clock; all state changes on the rising edge.
- `rst_n`, input, 1. Asynchronous active-low reset.
- `in_valid`, input, 1. An operand set is presented.
- `in_ready`, output, 1. Block can accept operands. High only in IDLE.
- `a`, input, WIDTH. Minuend.
- `b`, input, WIDTH. Subtrahend.
- `bin`, input, 1. Borrow-in.
- `out_valid`, output, 1. Result is presented.
- `out_ready`, input, 1. Consumer accepts the result.
- `diff`, output, WIDTH. `(a - b - bin) mod 2^WIDTH`.
- `bout`, output, 1. Borrow-out. 1 iff `a < b + bin` (unsigned).
- `ovf`, output, 1. Present only with `SUB_OVERFLOW_EN`; see Configuration.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`, latch `a`, `b` and `bin` into shift registers and the borrow flop, clear the bit counter, and go to RUN.
- **RUN**
  - Each cycle, the full subtractor takes `a_sh[0]`, `b_sh[0]` and `borrow` and produces `d` and `bo`.
  - `d` shifts into the MSB of the diff register. `a_sh` and `b_sh` shift right. `borrow` takes `bo`. The counter increments.
  - After the bit-(WIDTH-1) cycle, go to DONE.
- **DONE**
  - `out_valid`=1, and `diff` and `bout` are held stable.
  - On `out_ready`, go to IDLE.
- The block holds one operation at a time. Operand changes after acceptance have no effect.
- `in_valid` while not IDLE is ignored; no queuing.
- `out_ready` outside DONE is ignored.
- Arithmetic is unsigned modulo 2^WIDTH, and `bout` is the final borrow flop value.
- **Reset:** asserting `rst_n` low at any time, including mid-RUN or in DONE, aborts the operation and discards the result. The FSM goes to IDLE.
- **Reset values:**
  - `in_ready`=1, `out_valid`=0, `diff`=0, `bout`=0, `ovf`=0.
  - Internal shift registers, borrow flop and counter are 0.

## Timing
- Accept edge T0 is the first edge with `in_valid && in_ready`.
- RUN spans edges T1..TWIDTH, one bit per edge.
- `out_valid` rises after edge TWIDTH, so latency is WIDTH cycles from accept to `out_valid`.
- `in_ready` falls after T0 and rises again the cycle after the `out_valid && out_ready` edge.
- Minimum initiation interval is WIDTH+2 cycles when `out_ready` is held high.
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from any input.

## Configuration
- Macro `SUB_OVERFLOW_EN`.
- **Defined:** port `ovf` exists and is registered at the same edge as the final diff bit. `ovf` = `(a[W-1] != b[W-1]) && (diff[W-1] != a[W-1])` using the latched operand MSBs, i.e. two's-complement signed overflow of `a - b` (`bin` folded in). It is valid with `out_valid` and cleared on reset.
- **Undefined:** the `ovf` port and its logic are absent. All other behaviour is identical.

## Structure
- Package `serial_sub_pkg` contains:
  - State enum typedef `sub_state_t` (IDLE, RUN, DONE).
  - Default-width constant `SUB_WIDTH_DEF` = 4.
  - Counter-width function based on `$clog2(WIDTH)`.
- Sub-module `full_subtractor` has ports `a`, `b`, `bin`, `d`, `bout`. It is combinational with `d = a^b^bin` and `bout = (~a&b) | (~(a^b)&bin)`, and is instantiated once.

## Test plan
All scenarios use WIDTH=4.
- `a`=9, `b`=3, `bin`=0 -> `diff`=6, `bout`=0; `out_valid` rises exactly 4 cycles after accept.
- `a`=3, `b`=9, `bin`=0 -> `diff`=0xA, `bout`=1.
- `a`=0, `b`=0, `bin`=1 -> `diff`=0xF, `bout`=1. Also `a`=0xF, `b`=0xF, `bin`=0 -> `diff`=0, `bout`=0.
- Backpressure:
  - Hold `out_ready`=0 for 3 cycles in DONE -> `diff` and `bout` stable, `in_ready`=0, and a new `in_valid` is ignored.
  - Release `out_ready` -> `in_ready`=1 next cycle, and the next operand set (5-2) returns `diff`=3.
- Reset mid-operation:
  - Pull `rst_n` low 2 cycles into RUN -> `out_valid`=0, `diff`=0, `in_ready`=1 immediately.
  - The post-reset operation 8-1 returns `diff`=7.
- With `SUB_OVERFLOW_EN`:
  - `a`=0111, `b`=1000 -> `diff`=1111, `ovf`=1.
  - `a`=5, `b`=3 -> `ovf`=0.
  - `a`=1000, `b`=0001 -> `diff`=0111, `ovf`=1.
